// File: rtl/vec_result_collector_pkg.sv
// Shared constants and the lane-state encoding for the vectorized PE result collector.
package vec_result_collector_pkg;

  localparam int unsigned dwidth_float = 32;
  localparam int unsigned SIMD_degree  = 4;
  localparam int unsigned phit_size    = SIMD_degree * dwidth_float;
  localparam int unsigned KEEP_W       = phit_size / 8;
  localparam int unsigned LANE_KEEP_W  = dwidth_float / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_POP,
    S_FLUSH
  } lane_state_t;

endpackage

// File: rtl/vec_result_collector_lane_fifo.sv
// Per-lane result FIFO: show-ahead head, occupancy count, full/empty flags.
module lane_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A full FIFO still accepts a write when the same cycle frees an entry.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/vec_result_collector.sv
// Re-aligns skewed per-lane PE results into phit-wide AXI-Stream beats.
// Optional partial-beat timeout flush: define VEC_COLLECT_FLUSH_EN.
module vec_result_collector
  import vec_result_collector_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned AF_MARGIN    = 8,
  parameter int unsigned FLUSH_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [phit_size-1:0]   i_PE_data,
  input  logic [SIMD_degree-1:0] i_tvalid,
  input  logic [SIMD_degree-1:0] i_tlast,
  output logic                   o_almost_full,
  output logic [SIMD_degree-1:0] o_overflow,
  output logic                   o_tlast_err,
  output logic [phit_size-1:0]   m_axis_tdata,
  output logic [KEEP_W-1:0]      m_axis_tkeep,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned LW = dwidth_float + 1;

  if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      AF_MARGIN >= FIFO_DEPTH || FLUSH_CYCLES < 2) begin : g_bad_param
    $error("vec_result_collector: illegal parameter combination");
  end

  logic [LW-1:0]          head    [SIMD_degree];
  logic [CW-1:0]          cnt     [SIMD_degree];
  logic [CW-1:0]          cnt_nxt [SIMD_degree];
  logic [SIMD_degree-1:0] full;
  logic [SIMD_degree-1:0] empty;
  logic [SIMD_degree-1:0] rd;
  logic [SIMD_degree-1:0] wr_ok;
  logic [SIMD_degree-1:0] nxt_ne;
  logic [SIMD_degree-1:0] head_last;

  lane_state_t            state_q;
  lane_state_t            state_d;
  logic                   can_load;
  logic                   load;
  logic                   tlast_mis;
  logic                   af_nxt;
  logic [phit_size-1:0]   beat_data;
  logic [KEEP_W-1:0]      beat_keep;
  logic                   beat_last;

  for (genvar g = 0; g < SIMD_degree; g++) begin : g_lane
    lane_fifo #(
      .WIDTH (LW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (i_tvalid[g]),
      .wr_data ({i_tlast[g], i_PE_data[g*dwidth_float +: dwidth_float]}),
      .rd_en   (rd[g]),
      .rd_data (head[g]),
      .count   (cnt[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );

    assign head_last[g] = head[g][dwidth_float];
    assign wr_ok[g]     = i_tvalid[g] && (!full[g] || rd[g]);
    assign cnt_nxt[g]   = cnt[g] + CW'(wr_ok[g]) - CW'(rd[g]);
    assign nxt_ne[g]    = (cnt_nxt[g] != '0);
  end

`ifdef VEC_COLLECT_FLUSH_EN
  localparam int unsigned TW = $clog2(FLUSH_CYCLES) + 1;
  logic [TW-1:0] timer_q;

  // Counts consecutive cycles spent in S_WAIT; no pops happen there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                       timer_q <= '0;
    else if (state_q == S_WAIT && state_d == S_WAIT) timer_q <= timer_q + 1'b1;
    else                                           timer_q <= '0;
  end
`endif

  // State tracks post-update occupancy so a pop can fire the cycle after the write.
  always_comb begin
    can_load = !m_axis_tvalid || m_axis_tready;
    rd       = '0;
    load     = 1'b0;
    state_d  = state_q;
    case (state_q)
      S_POP: begin
        if (can_load) begin
          rd   = '1;
          load = 1'b1;
        end
      end
`ifdef VEC_COLLECT_FLUSH_EN
      S_FLUSH: begin
        if (can_load) begin
          rd   = ~empty;
          load = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    if (&nxt_ne)       state_d = S_POP;
    else if (~|nxt_ne) state_d = S_IDLE;
    else begin
`ifdef VEC_COLLECT_FLUSH_EN
      if (state_q == S_FLUSH && !load)
        state_d = S_FLUSH;
      else if (state_q == S_WAIT && timer_q >= TW'(FLUSH_CYCLES - 1))
        state_d = S_FLUSH;
      else
        state_d = S_WAIT;
`else
      state_d = S_WAIT;
`endif
    end
  end

  // Unpopped lanes contribute zero data and zero keep; a full pop gives all ones.
  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    af_nxt    = 1'b0;
    for (int unsigned l = 0; l < SIMD_degree; l++) begin
      beat_data[l*dwidth_float +: dwidth_float] = rd[l] ? head[l][dwidth_float-1:0] : '0;
      beat_keep[l*LANE_KEEP_W +: LANE_KEEP_W]   = {LANE_KEEP_W{rd[l]}};
      if (cnt_nxt[l] >= CW'(FIFO_DEPTH - AF_MARGIN)) af_nxt = 1'b1;
    end
    beat_last = |(head_last & rd);
    tlast_mis = (state_q == S_POP) && load && (head_last != '0) && (head_last != '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      o_almost_full <= 1'b0;
      o_overflow    <= '0;
      o_tlast_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= beat_data;
        m_axis_tkeep  <= beat_keep;
        m_axis_tlast  <= beat_last;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      o_almost_full <= af_nxt;
      o_overflow    <= o_overflow | (i_tvalid & full & ~rd);
      if (tlast_mis) o_tlast_err <= 1'b1;
    end
  end

endmodule
